// File: rtl/rv32i_pkg.sv
// Shared decode constants, encodings and helpers for the RV32I decode stage.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctrl_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U,
    IMM_NONE
  } imm_src_e;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        jalr;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [3:0]  alu_control;
    logic [2:0]  funct3;
    logic        illegal;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } idex_t;

  // Only bits [31:7] carry immediate fields; the opcode is not needed here.
  function automatic logic [31:0] imm_extend(input logic [31:7] ins, input imm_src_e src);
    logic [31:0] imm;
    case (src)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

  function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
    alu_ctrl_e op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decode_if.sv
// IF/ID inputs, writeback port and ID/EX outputs of the decode stage.
interface rv32i_decode_if #(parameter int XLEN = 32);

  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            FlushE;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;

  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic            JalrE;
  logic [1:0]      ALUSrcAE;
  logic            ALUSrcBE;
  logic [3:0]      ALUControlE;
  logic [2:0]      Funct3E;
  logic            IllegalE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic [XLEN-1:0] ImmExtE;

  modport slave (
    input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    output Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, JalrE,
           ALUSrcAE, ALUSrcBE, ALUControlE, Funct3E, IllegalE, RD1E, RD2E,
           PCE, PCPlus4E, Rs1E, Rs2E, RdE, ImmExtE
  );

  modport master (
    output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    input  Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, JalrE,
           ALUSrcAE, ALUSrcBE, ALUControlE, Funct3E, IllegalE, RD1E, RD2E,
           PCE, PCPlus4E, Rs1E, Rs2E, RdE, ImmExtE
  );

endinterface

// File: rtl/rv32i_regfile.sv
// 2-read / 1-write register file with x0 hardwired to zero and same-cycle write-through.
module rv32i_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Write-through lets decode see a W-stage result retiring in the same cycle.
  always_comb begin
    rd1_o = '0;
    if (ra1_i != '0) rd1_o = (wr_en && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
  end

  always_comb begin
    rd2_o = '0;
    if (ra2_i != '0) rd2_o = (wr_en && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
  end

endmodule

// File: rtl/rv32i_decode.sv
// RV32I decode stage: control decode, register read, immediate extend and the ID/EX register.
module rv32i_decode
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic           clk,
  input  logic           rst,
  rv32i_decode_if.slave  bus
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode   = bus.InstrD[6:0];
  assign f3       = bus.InstrD[14:12];
  assign f7       = bus.InstrD[31:25];
  assign bus.Rs1D = bus.InstrD[19:15];
  assign bus.Rs2D = bus.InstrD[24:20];

  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;

  rv32i_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (bus.InstrD[19:15]),
    .ra2_i (bus.InstrD[24:20]),
    .we_i  (bus.RegWriteW),
    .wa_i  (bus.RdW),
    .wd_i  (bus.ResultW),
    .rd1_o (rd1_d),
    .rd2_o (rd2_d)
  );

  logic        reg_write_d;
  logic [1:0]  result_src_d;
  logic        mem_write_d;
  logic        jump_d;
  logic        branch_d;
  logic        jalr_d;
  logic [1:0]  alu_src_a_d;
  logic        alu_src_b_d;
  alu_ctrl_e   alu_ctrl_d;
  imm_src_e    imm_src_d;
  logic        illegal_d;
  logic        bad_ls_f3;

  assign bad_ls_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);

  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = RES_ALU;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    jalr_d       = 1'b0;
    alu_src_a_d  = SRCA_RS1;
    alu_src_b_d  = 1'b0;
    alu_ctrl_d   = ALU_ADD;
    imm_src_d    = IMM_NONE;
    illegal_d    = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write_d = 1'b1;
        alu_ctrl_d  = alu_decode(f3, f7[5], 1'b1);
        illegal_d   = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_IALU: begin
        reg_write_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm_src_d   = IMM_I;
        alu_ctrl_d  = alu_decode(f3, f7[5], 1'b0);
        if (f3 == 3'b001)      illegal_d = (f7 != 7'b0000000);
        else if (f3 == 3'b101) illegal_d = !(f7 == 7'b0000000 || f7 == 7'b0100000);
      end
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        result_src_d = RES_MEM;
        alu_src_b_d  = 1'b1;
        imm_src_d    = IMM_I;
        illegal_d    = bad_ls_f3;
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm_src_d   = IMM_S;
        illegal_d   = bad_ls_f3;
      end
      OP_BRANCH: begin
        branch_d   = 1'b1;
        alu_ctrl_d = ALU_SUB;
        imm_src_d  = IMM_B;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        result_src_d = RES_PC4;
        jump_d       = 1'b1;
        alu_src_a_d  = SRCA_PC;
        alu_src_b_d  = 1'b1;
        imm_src_d    = IMM_J;
      end
      OP_JALR: begin
        reg_write_d  = 1'b1;
        result_src_d = RES_PC4;
        jump_d       = 1'b1;
        jalr_d       = 1'b1;
        alu_src_b_d  = 1'b1;
        imm_src_d    = IMM_I;
      end
      OP_LUI: begin
        reg_write_d = 1'b1;
        alu_src_a_d = SRCA_ZERO;
        alu_src_b_d = 1'b1;
        imm_src_d   = IMM_U;
      end
      OP_AUIPC: begin
        reg_write_d = 1'b1;
        alu_src_a_d = SRCA_PC;
        alu_src_b_d = 1'b1;
        imm_src_d   = IMM_U;
      end
      default: illegal_d = 1'b1;
    endcase
    // An illegal instruction travels down as a NOP; indices and operands still pass.
    if (illegal_d) begin
      reg_write_d  = 1'b0;
      result_src_d = RES_ALU;
      mem_write_d  = 1'b0;
      jump_d       = 1'b0;
      branch_d     = 1'b0;
      jalr_d       = 1'b0;
      alu_src_a_d  = SRCA_RS1;
      alu_src_b_d  = 1'b0;
      alu_ctrl_d   = ALU_ADD;
    end
  end

  idex_t idex_d;
  idex_t idex_q;

  always_comb begin
    idex_d             = '0;
    idex_d.reg_write   = reg_write_d;
    idex_d.result_src  = result_src_d;
    idex_d.mem_write   = mem_write_d;
    idex_d.jump        = jump_d;
    idex_d.branch      = branch_d;
    idex_d.jalr        = jalr_d;
    idex_d.alu_src_a   = alu_src_a_d;
    idex_d.alu_src_b   = alu_src_b_d;
    idex_d.alu_control = alu_ctrl_d;
    idex_d.funct3      = f3;
    idex_d.illegal     = illegal_d;
    idex_d.rd1         = rd1_d;
    idex_d.rd2         = rd2_d;
    idex_d.pc          = bus.PCD;
    idex_d.pc_plus4    = bus.PCPlus4D;
    idex_d.rs1         = bus.InstrD[19:15];
    idex_d.rs2         = bus.InstrD[24:20];
    idex_d.rd          = bus.InstrD[11:7];
    idex_d.imm         = imm_extend(bus.InstrD[31:7], imm_src_d);
  end

  // ID/EX boundary: reset and flush both load an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushE) idex_q <= '0;
    else                   idex_q <= idex_d;
  end

  assign bus.RegWriteE   = idex_q.reg_write;
  assign bus.ResultSrcE  = idex_q.result_src;
  assign bus.MemWriteE   = idex_q.mem_write;
  assign bus.JumpE       = idex_q.jump;
  assign bus.BranchE     = idex_q.branch;
  assign bus.JalrE       = idex_q.jalr;
  assign bus.ALUSrcAE    = idex_q.alu_src_a;
  assign bus.ALUSrcBE    = idex_q.alu_src_b;
  assign bus.ALUControlE = idex_q.alu_control;
  assign bus.Funct3E     = idex_q.funct3;
  assign bus.IllegalE    = idex_q.illegal;
  assign bus.RD1E        = idex_q.rd1;
  assign bus.RD2E        = idex_q.rd2;
  assign bus.PCE         = idex_q.pc;
  assign bus.PCPlus4E    = idex_q.pc_plus4;
  assign bus.Rs1E        = idex_q.rs1;
  assign bus.Rs2E        = idex_q.rs2;
  assign bus.RdE         = idex_q.rd;
  assign bus.ImmExtE     = idex_q.imm;

endmodule
